melody_sequencer: RTL and testbench

//  Plays a stored song by sequencing the 4-bit note code and make_sound enable into the square-wave sound controller.

---
 rtl/melody_pkg.sv | 23 ++
 rtl/melody_sequencer_if.sv | 35 +++
 rtl/melody_sequencer_note_timer.sv | 44 ++++
 rtl/melody_sequencer.sv | 139 +++++++++++++
 tb/tb_melody_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/melody_pkg.sv
// Shared types and ROM entry layout for the melody sequencer.
package melody_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      PLAY  = 2'd3
   } state_e;

   localparam int NOTE_LSB = 0;
   localparam int NOTE_MSB = 3;
   localparam int DUR_LSB  = 4;
   localparam int DUR_MSB  = 6;
   localparam int REST_BIT = 7;

   localparam logic [7:0] END_MARKER = 8'hF0;

   function automatic logic is_end_marker(input logic [7:0] entry);
      return entry == END_MARKER;
   endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control, song-ROM and sound-controller signals of the melody sequencer.
// MELODY_TEMPO_EN adds the tempo_sel input.
interface melody_sequencer_if #(parameter int ADDR_W = 5);

   logic              start;
   logic              stop;
   logic              loop_en;
`ifdef MELODY_TEMPO_EN
   logic [1:0]        tempo_sel;
`endif
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic [3:0]        note;
   logic              make_sound;
   logic              busy;
   logic              step_pulse;
   logic              done;

   modport master (
`ifdef MELODY_TEMPO_EN
      output tempo_sel,
`endif
      output start, stop, loop_en, rom_data,
      input  rom_addr, note, make_sound, busy, step_pulse, done
   );

   modport slave (
`ifdef MELODY_TEMPO_EN
      input  tempo_sel,
`endif
      input  start, stop, loop_en, rom_data,
      output rom_addr, note, make_sound, busy, step_pulse, done
   );

endinterface

// File: rtl/melody_sequencer_note_timer.sv
// Per-note cycle counter: counts 0..last after a load pulse, opens the sound
// window for all but the final gap cycles and flags the final cycle.
module note_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] last,
   input  logic [CNT_W-1:0] gap,
   output logic             sound_window,
   output logic             expired
);

   logic             active;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] last_r;
   logic [CNT_W-1:0] gap_r;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         active  <= 1'b0;
         cyc_cnt <= '0;
         last_r  <= '0;
         gap_r   <= '0;
      end else if (load) begin
         active  <= 1'b1;
         cyc_cnt <= '0;
         last_r  <= last;
         gap_r   <= gap;
      end else if (active) begin
         if (cyc_cnt == last_r) active <= 1'b0;
         else                   cyc_cnt <= cyc_cnt + 1'b1;
      end
   end

   assign expired = active && (cyc_cnt == last_r);

   // cyc_cnt < len - gap, rewritten on last = len-1 so nothing can underflow.
   assign sound_window = active && (({1'b0, cyc_cnt} + {1'b0, gap_r}) <= {1'b0, last_r});

endmodule

// File: rtl/melody_sequencer.sv
// Song sequencer: fetches ROM entries, holds each note for its duration and
// drives note/make_sound into the sound controller. MELODY_TEMPO_EN enables tempo_sel.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int TICK_CYCLES = 6_250_000,
   parameter int GAP_CYCLES  = 1_000_000,
   parameter int SONG_LEN    = 32,
   parameter int ADDR_W      = 5
) (
   input  logic               clock,
   input  logic               reset,
   melody_sequencer_if.slave  bus
);

   localparam int CNT_W = $clog2(8 * TICK_CYCLES);
   localparam int LW    = CNT_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

   state_e            state, state_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [3:0]        note_r;
   logic              rest_r;
   logic              done_r, done_n;
   logic              step_r, step_n;
   logic              latch;
   logic              tmr_load, tmr_clear;
   logic              sound_window, expired;

   logic [LW-1:0]     tick_len, n_ticks, note_len;
   logic [CNT_W-1:0]  gap_len, last_cnt;

   // Note length is computed while the entry sits on rom_data during LOAD.
   always_comb begin
`ifdef MELODY_TEMPO_EN
      tick_len = LW'(TICK_CYCLES >> bus.tempo_sel);
      gap_len  = CNT_W'(GAP_CYCLES >> bus.tempo_sel);
`else
      tick_len = LW'(TICK_CYCLES);
      gap_len  = CNT_W'(GAP_CYCLES);
`endif
      n_ticks  = LW'(bus.rom_data[DUR_MSB:DUR_LSB]) + LW'(1);
      note_len = n_ticks * tick_len;
      last_cnt = CNT_W'(note_len - LW'(1));
   end

   note_timer #(.CNT_W(CNT_W)) u_timer (
      .clock        (clock),
      .reset        (reset),
      .clear        (tmr_clear),
      .load         (tmr_load),
      .last         (last_cnt),
      .gap          (gap_len),
      .sound_window (sound_window),
      .expired      (expired)
   );

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_n   = state;
      addr_n    = addr;
      done_n    = 1'b0;
      step_n    = 1'b0;
      latch     = 1'b0;
      tmr_load  = 1'b0;
      tmr_clear = 1'b0;

      if (bus.stop && state != IDLE) begin
         state_n   = IDLE;
         addr_n    = '0;
         done_n    = 1'b1;
         tmr_clear = 1'b1;
      end else begin
         case (state)
            IDLE: if (bus.start) state_n = FETCH;
            FETCH: state_n = LOAD;
            LOAD: begin
               if (is_end_marker(bus.rom_data)) begin
                  addr_n = '0;
                  if (bus.loop_en) state_n = FETCH;
                  else begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end else begin
                  state_n  = PLAY;
                  latch    = 1'b1;
                  tmr_load = 1'b1;
                  step_n   = 1'b1;
               end
            end
            PLAY: begin
               if (expired) begin
                  if (addr == LAST_ADDR) begin
                     addr_n = '0;
                     if (bus.loop_en) state_n = FETCH;
                     else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                     end
                  end else begin
                     addr_n  = addr + 1'b1;
                     state_n = FETCH;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         addr   <= '0;
         note_r <= '0;
         rest_r <= 1'b0;
         done_r <= 1'b0;
         step_r <= 1'b0;
      end else begin
         state  <= state_n;
         addr   <= addr_n;
         done_r <= done_n;
         step_r <= step_n;
         if (latch) begin
            note_r <= bus.rom_data[NOTE_MSB:NOTE_LSB];
            rest_r <= bus.rom_data[REST_BIT];
         end
      end
   end

   assign bus.rom_addr   = addr;
   assign bus.note       = note_r;
   assign bus.make_sound = (state == PLAY) && !rest_r && sound_window;
   assign bus.busy       = (state != IDLE);
   assign bus.step_pulse = step_r;
   assign bus.done       = done_r;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed and randomized songs
// compared cycle by cycle against a timeline model of the song.
module tb_melody_sequencer;

   localparam int TICK     = 10;
   localparam int GAP      = 2;
   localparam int SONG_LEN = 4;
   localparam int ADDR_W   = 2;
   localparam int MAXC     = 400;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   melody_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   melody_sequencer #(
      .TICK_CYCLES (TICK),
      .GAP_CYCLES  (GAP),
      .SONG_LEN    (SONG_LEN),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Synchronous-read song ROM
   logic [7:0] rom [SONG_LEN];
   always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

   int total = 0;
   int bad   = 0;
   int tempo_m = 0;
   logic [3:0] model_note = 4'h0;

   bit              e_busy [MAXC];
   bit              e_ms   [MAXC];
   bit              e_step [MAXC];
   bit              e_done [MAXC];
   logic [3:0]      e_note [MAXC];
   logic [ADDR_W-1:0] e_addr [MAXC];

   task automatic check(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle %0d: observed=%0h expected=%0h", tag, c, obs, exp);
      end
   endtask

   // Timeline of one song started at cycle 0: each entry is two silent
   // fetch cycles followed by len play cycles, the last gap of them silent.
   task automatic build(input bit lp, output int end_t);
      int t, a, len, tick_m, gap_m, c;
      logic [7:0] e;
      logic [3:0] cur;
      bit ended;
      tick_m = TICK >> tempo_m;
      gap_m  = GAP >> tempo_m;
      cur    = model_note;
      for (int k = 0; k < MAXC; k++) begin
         e_busy[k] = 0; e_ms[k] = 0; e_step[k] = 0; e_done[k] = 0;
         e_note[k] = cur; e_addr[k] = '0;
      end
      t = 1; a = 0; ended = 0; end_t = -1;
      while (!ended && t + 1 < MAXC) begin
         e = rom[a];
         for (int k = 0; k < 2; k++) begin
            e_busy[t+k] = 1; e_note[t+k] = cur; e_addr[t+k] = ADDR_W'(a);
         end
         if (e == 8'hF0) begin
            if (lp) begin a = 0; t += 2; end
            else begin end_t = t + 2; ended = 1; end
         end else begin
            len = (int'(e[6:4]) + 1) * tick_m;
            cur = e[3:0];
            for (int i = 0; i < len && t + 2 + i < MAXC; i++) begin
               c = t + 2 + i;
               e_busy[c] = 1; e_note[c] = cur; e_addr[c] = ADDR_W'(a);
               e_ms[c]   = !e[7] && (i < len - gap_m);
               e_step[c] = (i == 0);
            end
            t += 2 + len;
            if (a == SONG_LEN - 1) begin
               a = 0;
               if (!lp) begin end_t = t; ended = 1; end
            end else a++;
         end
      end
      if (ended && end_t < MAXC) begin
         e_done[end_t] = 1;
         for (int k = end_t; k < MAXC; k++) e_note[k] = cur;
      end
   endtask

   task automatic run_phase(input bit lp, input int stop_c, input int rst_c, input int extra_c);
      int end_t, n, xc;
      logic [3:0] held;
      build(lp, end_t);
      n = MAXC;
      if (end_t >= 0) n = end_t + 3;
      if (stop_c > 0 && stop_c + 3 < n) n = stop_c + 3;
      if (stop_c > 0 && stop_c < n && e_busy[stop_c]) begin
         held = e_note[stop_c];
         for (int k = stop_c + 1; k < MAXC; k++) begin
            e_busy[k] = 0; e_ms[k] = 0; e_step[k] = 0; e_addr[k] = '0;
            e_note[k] = held; e_done[k] = (k == stop_c + 1);
         end
      end
      if (rst_c > 0 && rst_c + 3 < n) n = rst_c + 3;
      if (rst_c > 0 && rst_c < n) begin
         for (int k = rst_c + 1; k < MAXC; k++) begin
            e_busy[k] = 0; e_ms[k] = 0; e_step[k] = 0; e_done[k] = 0;
            e_addr[k] = '0; e_note[k] = 4'h0;
         end
      end
      xc = (extra_c > 0 && extra_c < n && e_busy[extra_c]) ? extra_c : -1;
      bus.loop_en = lp;
      for (int c = 0; c < n; c++) begin
         bus.start = (c == 0) || (c == stop_c) || (c == xc);
         bus.stop  = (c == stop_c);
         reset     = (c == rst_c);
         @(negedge clock);
         check("busy",       c, 8'(bus.busy),       8'(e_busy[c]));
         check("make_sound", c, 8'(bus.make_sound), 8'(e_ms[c]));
         check("step_pulse", c, 8'(bus.step_pulse), 8'(e_step[c]));
         check("done",       c, 8'(bus.done),       8'(e_done[c]));
         check("note",       c, 8'(bus.note),       8'(e_note[c]));
         check("rom_addr",   c, 8'(bus.rom_addr),   8'(e_addr[c]));
         @(posedge clock);
         #1;
      end
      bus.start = 0; bus.stop = 0; reset = 0;
      model_note = e_note[n-1];
   endtask

   initial begin
      int stop_c;
      bit lp;
      reset = 1; bus.start = 0; bus.stop = 0; bus.loop_en = 0;
`ifdef MELODY_TEMPO_EN
      bus.tempo_sel = 2'd0;
`endif
      foreach (rom[i]) rom[i] = 8'h00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy",       0, 8'(bus.busy),       8'h00);
      check("rst_make_sound", 0, 8'(bus.make_sound), 8'h00);
      check("rst_step",       0, 8'(bus.step_pulse), 8'h00);
      check("rst_done",       0, 8'(bus.done),       8'h00);
      check("rst_note",       0, 8'(bus.note),       8'h00);
      check("rst_addr",       0, 8'(bus.rom_addr),   8'h00);
      @(posedge clock);
      #1;
      reset = 0;

      // Basic song with a rest entry, no loop
      rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h80; rom[3] = 8'h07;
      run_phase(0, -1, -1, 20);
      // Looping song, stopped during the third pass
      run_phase(1, 130, -1, 60);
      // END marker at entry 1
      rom[1] = 8'hF0; rom[2] = 8'h2A; rom[3] = 8'h3B;
      run_phase(0, -1, -1, -1);
      // Stop with simultaneous start mid-note, then replay
      rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h80; rom[3] = 8'h07;
      run_phase(0, 6, -1, -1);
      run_phase(0, -1, -1, -1);
      // Reset mid-play, then a clean start
      run_phase(0, -1, 6, -1);
      run_phase(0, -1, -1, -1);
`ifdef MELODY_TEMPO_EN
      tempo_m = 1; bus.tempo_sel = 2'd1;
      rom[0] = 8'h01; rom[1] = 8'h12; rom[2] = 8'h83; rom[3] = 8'h04;
      run_phase(0, -1, -1, -1);
      tempo_m = 0; bus.tempo_sel = 2'd0;
`endif

      for (int p = 0; p < 6; p++) begin
         foreach (rom[i]) begin
            if ($urandom_range(0, 7) == 0) rom[i] = 8'hF0;
            else rom[i] = {($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
         end
         lp = 1'($urandom_range(0, 1));
         if (lp) stop_c = $urandom_range(20, 200);
         else    stop_c = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 100) : -1;
         run_phase(lp, stop_c, -1, $urandom_range(1, 120));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
